// File: rtl/sbase_step_exec.sv
// Sequencer step executor: step0 loads A, step1 loads B, step2 runs an 8-cycle shift-add A*B, step3 accumulates P.
// Latency: steps 0/1/3 complete next cycle, step 2 completes 9 cycles after accept; pulses while BUSY are dropped and set ERR.
module sbase_step_exec (
  input  logic        CLK,
  input  logic        R,
  input  logic        STATE0,
  input  logic        STATE1,
  input  logic        STATE2,
  input  logic        STATE3,
  input  logic        POUT_ONE0,
  input  logic        POUT_ONE1,
  input  logic        POUT_ONE2,
  input  logic        POUT_ONE3,
  input  logic [7:0]  DIN,
  input  logic        ACC_CLR,
  output logic        STEP_DONE,
  output logic        BUSY,
  output logic [19:0] DOUT,
  output logic        DOUT_VLD,
  output logic        ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pulse, step_sel;
  logic        pulse_any, pulse_one, pulse_match, accept;
  logic        go0, go1, go2, go3;
  logic        last_iter;
  logic        busy_d, done_d, vld_d, err_d;
  logic [7:0]  a_q, b_q, mplier_q;
  logic [15:0] p_q, mcand_q, prod_q, prod_step;
  logic [2:0]  cnt_q;
  logic [19:0] acc_q;

  assign pulse    = {POUT_ONE3, POUT_ONE2, POUT_ONE1, POUT_ONE0};
  assign step_sel = {STATE3, STATE2, STATE1, STATE0};

  // Accept only a single pulse that agrees with the sequencer state and arrives while idle.
  assign pulse_any   = |pulse;
  assign pulse_one   = pulse_any && ((pulse & (pulse - 4'd1)) == 4'd0);
  assign pulse_match = (pulse & step_sel) == pulse;
  assign accept      = pulse_one && pulse_match && !BUSY;

  assign go0 = accept && pulse[0];
  assign go1 = accept && pulse[1];
  assign go2 = accept && pulse[2];
  assign go3 = accept && pulse[3];

  assign last_iter = (state_q == MUL) && (cnt_q == 3'd7);
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : 16'd0);
  assign DOUT      = acc_q;

  always_ff @(posedge CLK) begin
    if (!R) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go2) state_d = MUL;
      MUL:     if (cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = go2 ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == MUL);
    done_d = go0 || go1 || go3 || last_iter;
    vld_d  = go3;
    err_d  = ERR || (pulse_any && !accept);
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      BUSY      <= 1'b0;
      STEP_DONE <= 1'b0;
      DOUT_VLD  <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      BUSY      <= busy_d;
      STEP_DONE <= done_d;
      DOUT_VLD  <= vld_d;
      ERR       <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      p_q      <= 16'd0;
      acc_q    <= 20'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 8'd0;
      prod_q   <= 16'd0;
      cnt_q    <= 3'd0;
    end else begin
      if (go0) a_q <= DIN;
      if (go1) b_q <= DIN;

      // P keeps its previous value until the final partial product is folded in.
      if (go2) begin
        mcand_q  <= {8'd0, a_q};
        mplier_q <= b_q;
        prod_q   <= 16'd0;
        cnt_q    <= 3'd0;
      end else if (state_q == MUL) begin
        prod_q   <= prod_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) p_q <= prod_step;
      end

      if (go3) begin
        acc_q <= (ACC_CLR ? 20'd0 : acc_q) + {4'd0, p_q};
      end else if (ACC_CLR) begin
        acc_q <= 20'd0;
      end
    end
  end

endmodule

// File: doc/sbase_step_exec.md
SBASE_STEP_EXEC -- requirements
Module: sbase_step_exec

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- CLK  in  1  single system clock; all state updates on rising edge.
- R  in  1  reset; synchronous, active-low (R=0 at a rising edge resets).
- STATE0..STATE3  in  1 each  one-hot step indication from the 4-state sequencer.
- POUT_ONE0..POUT_ONE3  in  1 each  one-cycle step-start pulses from the sequencer.
- DIN  in  8  operand data, sampled on step-0/step-1 pulses.
- ACC_CLR  in  1  synchronous accumulator clear request.
- STEP_DONE  out  1  one-cycle pulse when the current step completes; drives the sequencer RDY_IN.
- BUSY  out  1  high while the multiply is in progress.
- DOUT  out  20  accumulator value.
- DOUT_VLD  out  1  one-cycle pulse when DOUT has been updated by step 3.
- ERR  out  1  sticky protocol-error flag.
REQ-002 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Function
REQ-003 A step pulse SHALL be accepted only when exactly one POUT_ONEn is high, the matching STATEn is high, and BUSY=0.
REQ-004 Step 0: on an accepted POUT_ONE0 in cycle t, A <= DIN at the end of t; STEP_DONE=1 in cycle t+1 only.
REQ-005 Step 1: on an accepted POUT_ONE1 in cycle t, B <= DIN at the end of t; STEP_DONE=1 in cycle t+1 only.
REQ-006 Step 2: on an accepted POUT_ONE2 in cycle t, the block SHALL start an unsigned 8x8 shift-add multiply, one bit per cycle, over 8 cycles.
- BUSY=1 in cycles t+1..t+8.
- In cycle t+9: P (16 bit) = A*B is valid, BUSY=0, STEP_DONE=1.
REQ-007 Step 3: on an accepted POUT_ONE3 in cycle t, ACC <= (ACC + zero-extended P) mod 2^20.
- In cycle t+1: DOUT = new ACC, DOUT_VLD=1, STEP_DONE=1.
REQ-008 Internal control FSM states:
- IDLE -> MUL on accepted step 2.
- MUL -> DONE after the 8th iteration.
- DONE -> IDLE after one cycle.
- Steps 0, 1 and 3 SHALL complete from IDLE without leaving it.
REQ-009 ACC_CLR=1 with no step-3 pulse in the same cycle SHALL set ACC to 0; DOUT SHALL show 0 the next cycle; DOUT_VLD SHALL stay 0.
REQ-010 ACC_CLR=1 and an accepted POUT_ONE3 in the same cycle SHALL set ACC <= P (the clear applies first, then the add).
REQ-011 The following SHALL be ignored and SHALL set ERR=1, which holds until reset:
- any POUT_ONEn while BUSY=1;
- two or more POUT_ONEn high in one cycle;
- POUT_ONEn without the matching STATEn.
An ignored pulse SHALL change no other state and SHALL produce no STEP_DONE.
REQ-012 A, B and P SHALL hold their values between steps; repeating step 2 without reloading SHALL recompute the same P.
REQ-013 STEP_DONE and DOUT_VLD SHALL never be high for two consecutive cycles.

Reset
REQ-014 R=0 at a rising edge SHALL force, in the next cycle:
- FSM=IDLE;
- A, B, P and ACC = 0;
- DOUT=0, STEP_DONE=0, BUSY=0, DOUT_VLD=0, ERR=0.
REQ-015 Reset SHALL take priority over every other input, including mid-multiply, and the aborted step SHALL produce no STEP_DONE.
REQ-016 After R returns to 1, the block SHALL accept a step pulse in the very next cycle.

Verification
REQ-017 Run the sequence in steps 0..3 with A=12, B=13, ACC=0.
- Step 0 and step 1: STEP_DONE one cycle after each pulse.
- Step 2: BUSY high 8 cycles, then STEP_DONE.
- Step 3: DOUT=156 with DOUT_VLD.
REQ-018 Run 17 full sequences with A=B=255.
- P=65025 each time.
- DOUT after the 16th sequence = 1040400.
- DOUT after the 17th sequence = 56849 (20-bit wrap).
REQ-019 Drive POUT_ONE0 (DIN=99) in cycle t+3 of a multiply.
- A is unchanged.
- ERR=1 from the next cycle and holds.
- The multiply completes normally with STEP_DONE at t+9.
REQ-020 Drive R=0 in cycle t+4 of a multiply.
- Next cycle: BUSY=0, DOUT=0, ERR=0.
- No STEP_DONE appears.
- A fresh step 0 issued right after R=1 completes normally.
REQ-021 With ACC=1000 and P=156, assert ACC_CLR together with POUT_ONE3: next cycle DOUT=156, DOUT_VLD=1.
REQ-022 Assert POUT_ONE1 and POUT_ONE3 in the same cycle: ERR=1, no STEP_DONE, B and ACC unchanged.
